// File: rtl/aes_decryption_controller.sv
// Control FSM for the iterative AES-128 decryption datapath: sequences load,
// optional key expansion, the inverse rounds and the final output register.
module aes_decryption_controller #(
    parameter int EXPAND_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic new_key,
    input  logic count_gt_0,
    input  logic count_eq_9,
    input  logic expand_done,
    output logic ready,
    output logic done,
    output logic err,
    output logic init,
    output logic key_init,
    output logic key_step,
    output logic store_key,
    output logic dec_count,
    output logic isRound10,
    output logic isRound9,
    output logic en_round_out,
    output logic en_reg_inv_row_out,
    output logic en_reg_inv_sub_out,
    output logic en_reg_inv_col_out,
    output logic en_Dout
);

    localparam int TW = $clog2(EXPAND_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_EXPAND, S_R10, S_SHIFT,
        S_SUB, S_ADDKEY, S_MIX, S_DONE, S_ERROR
    } state_t;

    state_t        state, state_nxt;
    logic          expand_path, expand_path_nxt;
    logic          key_valid, key_valid_nxt;
    logic [TW-1:0] timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            expand_path <= 1'b0;
            key_valid   <= 1'b0;
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            expand_path <= expand_path_nxt;
            key_valid   <= key_valid_nxt;
            // Timer only runs while expanding; LOAD always precedes EXPAND.
            if (state == S_LOAD)
                timer <= '0;
            else if (state == S_EXPAND)
                timer <= timer + TW'(1);
        end
    end

    always_comb begin
        state_nxt          = state;
        expand_path_nxt    = expand_path;
        key_valid_nxt      = key_valid;
        ready              = 1'b0;
        done               = 1'b0;
        err                = 1'b0;
        init               = 1'b0;
        key_init           = 1'b0;
        key_step           = 1'b0;
        store_key          = 1'b0;
        dec_count          = 1'b0;
        isRound10          = 1'b0;
        isRound9           = 1'b0;
        en_round_out       = 1'b0;
        en_reg_inv_row_out = 1'b0;
        en_reg_inv_sub_out = 1'b0;
        en_reg_inv_col_out = 1'b0;
        en_Dout            = 1'b0;

        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt       = S_LOAD;
                    expand_path_nxt = new_key | ~key_valid;
                    // The stored schedule is about to be overwritten.
                    if (new_key | ~key_valid)
                        key_valid_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                init      = 1'b1;
                key_init  = expand_path;
                state_nxt = expand_path ? S_EXPAND : S_R10;
            end
            S_EXPAND: begin
                store_key = 1'b1;
                key_step  = ~expand_done;
                if (expand_done) begin
                    state_nxt     = S_R10;
                    key_valid_nxt = 1'b1;
                end else if (timer == TW'(EXPAND_TIMEOUT - 1)) begin
                    state_nxt = S_ERROR;
                end
            end
            S_R10: begin
                isRound10    = 1'b1;
                en_round_out = 1'b1;
                dec_count    = 1'b1;
                state_nxt    = S_SHIFT;
            end
            S_SHIFT: begin
                isRound9           = count_eq_9;
                en_reg_inv_row_out = 1'b1;
                state_nxt          = S_SUB;
            end
            S_SUB: begin
                en_reg_inv_sub_out = 1'b1;
                state_nxt          = S_ADDKEY;
            end
            S_ADDKEY: begin
                if (count_gt_0) begin
                    en_round_out = 1'b1;
                    dec_count    = 1'b1;
                    state_nxt    = S_MIX;
                end else begin
                    en_Dout   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_MIX: begin
                en_reg_inv_col_out = 1'b1;
                state_nxt          = S_SHIFT;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
